// File: rtl/mem_port_arbiter.sv
// Shared IF/MEM port arbiter for the unified memory, MEM-first with IF starvation guard.
// Define MEM_ARB_TIMEOUT_EN to abort bus accesses that wait TIMEOUT cycles (bus_err).
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic              bus_err,
   output logic              if_stall,
   output logic              mem_stall
);

   typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_IF, ACK} state_t;

   localparam logic [2:0] SMAX = 3'(STARVE_MAX);

   if (STARVE_MAX < 1 || STARVE_MAX > 7 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
      $error("mem_port_arbiter: parameter out of range");
   end

   state_t            state_q, state_d;
   logic              own_mem_q, own_mem_d;
   logic [2:0]        starve_q, starve_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rd_q, if_rd_d;
   logic [DATA_W-1:0] mem_rd_q, mem_rd_d;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [3:0] TLAST = 4'(TIMEOUT - 1);
   logic [3:0] wait_q, wait_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      own_mem_d = own_mem_q;
      starve_d  = starve_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      if_rd_d   = if_rd_q;
      mem_rd_d  = mem_rd_q;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_d    = wait_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
            wait_d = 4'd0;
            err_d  = 1'b0;
`endif
            if (mem_req && (!if_req || starve_q < SMAX)) begin
               state_d   = GNT_MEM;
               own_mem_d = 1'b1;
               we_d      = mem_we;
               addr_d    = mem_addr;
               wdata_d   = mem_wdata;
               if (if_req && starve_q != 3'd7)
                  starve_d = starve_q + 3'd1;
            end else if (if_req) begin
               state_d   = GNT_IF;
               own_mem_d = 1'b0;
               we_d      = 1'b0;
               addr_d    = if_addr;
               starve_d  = 3'd0;
            end
         end
         GNT_MEM, GNT_IF: begin
            if (bus_ready) begin
               state_d = ACK;
               if (own_mem_q) mem_rd_d = bus_rdata;
               else           if_rd_d  = bus_rdata;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (wait_q == TLAST) begin
               // abandoned access completes with zero data and an error flag
               state_d = ACK;
               err_d   = 1'b1;
               if (own_mem_q) mem_rd_d = '0;
               else           if_rd_d  = '0;
            end else begin
               wait_d = wait_q + 4'd1;
            end
`endif
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         own_mem_q <= 1'b0;
         starve_q  <= 3'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         if_rd_q   <= '0;
         mem_rd_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         wait_q    <= 4'd0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         own_mem_q <= own_mem_d;
         starve_q  <= starve_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         if_rd_q   <= if_rd_d;
         mem_rd_q  <= mem_rd_d;
`ifdef MEM_ARB_TIMEOUT_EN
         wait_q    <= wait_d;
         err_q     <= err_d;
`endif
      end
   end

   assign bus_req   = (state_q == GNT_MEM) || (state_q == GNT_IF);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign if_rdata  = if_rd_q;
   assign mem_rdata = mem_rd_q;
   assign if_ack    = (state_q == ACK) && !own_mem_q;
   assign mem_ack   = (state_q == ACK) && own_mem_q;
   assign if_stall  = if_req & ~if_ack;
   assign mem_stall = mem_req & ~mem_ack;
`ifdef MEM_ARB_TIMEOUT_EN
   assign bus_err   = (state_q == ACK) && err_q;
`else
   assign bus_err   = 1'b0;
`endif

endmodule
